// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the sequential floating-point divider:
// FSM states, flag bit positions, field extraction and special-value builders.
package fp_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_NORM   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int FLG_INVALID = 3;
  localparam int FLG_DIV0    = 2;
  localparam int FLG_OVF     = 1;
  localparam int FLG_UDF     = 0;

  // Helpers work on a zero-extended 32-bit view so any EXP_W/MAN_W up to 32 bits total fits.
  localparam int FIELD_W = 32;
  typedef logic [FIELD_W-1:0] field_t;

  function automatic field_t ones(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic field_t exp_field(input field_t word, input int exp_w, input int man_w);
    return (word >> man_w) & ones(exp_w);
  endfunction

  function automatic field_t man_field(input field_t word, input int man_w);
    return word & ones(man_w);
  endfunction

  function automatic logic is_zero(input field_t e);
    return (e == 32'd0);
  endfunction

  function automatic logic is_inf(input field_t e, input field_t m, input int exp_w);
    return (e == ones(exp_w)) && (m == 32'd0);
  endfunction

  function automatic logic is_nan(input field_t e, input field_t m, input int exp_w);
    return (e == ones(exp_w)) && (m != 32'd0);
  endfunction

  function automatic field_t nan_word(input int exp_w, input int man_w);
    return (ones(exp_w) << man_w) | (32'd1 << (man_w - 1));
  endfunction

  function automatic field_t inf_word(input logic sign, input int exp_w, input int man_w);
    return (field_t'(sign) << (exp_w + man_w)) | (ones(exp_w) << man_w);
  endfunction

  function automatic field_t zero_word(input logic sign, input int exp_w, input int man_w);
    return field_t'(sign) << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_div_special.sv
// Combinational operand classifier: flags NaN/inf/zero operand combinations
// and supplies the finished result and exception flags for them.
module fp_div_special
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 6
) (
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic                 hit_o,
  output logic [EXP_W+MAN_W:0] result_o,
  output logic [3:0]           flags_o
);

  localparam int W = 1 + EXP_W + MAN_W;

  field_t a_s, b_s, ea_s, ma_s, eb_s, mb_s;
  logic   sign_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;

  assign a_s      = FIELD_W'(a_i);
  assign b_s      = FIELD_W'(b_i);
  assign ea_s     = exp_field(a_s, EXP_W, MAN_W);
  assign eb_s     = exp_field(b_s, EXP_W, MAN_W);
  assign ma_s     = man_field(a_s, MAN_W);
  assign mb_s     = man_field(b_s, MAN_W);
  assign sign_s   = a_i[W-1] ^ b_i[W-1];
  // Exponent field 0 means zero whatever the mantissa: subnormals are flushed.
  assign a_zero_s = is_zero(ea_s);
  assign b_zero_s = is_zero(eb_s);
  assign a_inf_s  = is_inf(ea_s, ma_s, EXP_W);
  assign b_inf_s  = is_inf(eb_s, mb_s, EXP_W);
  assign a_nan_s  = is_nan(ea_s, ma_s, EXP_W);
  assign b_nan_s  = is_nan(eb_s, mb_s, EXP_W);

  // Priority-ordered special-case decode.
  always_comb begin
    hit_o    = 1'b1;
    result_o = {W{1'b0}};
    flags_o  = 4'b0000;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      result_o              = W'(nan_word(EXP_W, MAN_W));
      flags_o[FLG_INVALID]  = 1'b1;
    end else if (b_zero_s) begin
      result_o              = W'(inf_word(sign_s, EXP_W, MAN_W));
      flags_o[FLG_DIV0]     = 1'b1;
    end else if (a_inf_s) begin
      result_o              = W'(inf_word(sign_s, EXP_W, MAN_W));
    end else if (b_inf_s || a_zero_s) begin
      result_o              = W'(zero_word(sign_s, EXP_W, MAN_W));
    end else begin
      hit_o                 = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle radix-2 restoring floating-point divider with valid/ready handshake.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] data_input_1,
  input  logic [EXP_W+MAN_W:0] data_input_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] data_output,
  output logic [3:0]           flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int Q_W   = MAN_W + 3;
  localparam int R_W   = MAN_W + 2;
  localparam int CNT_W = $clog2(MAN_W + 4);
  localparam logic [CNT_W-1:0]       LAST_CNT  = CNT_W'(MAN_W + 2);
  localparam logic signed [EXP_W+1:0] BIAS_S    = (EXP_W+2)'(2**(EXP_W-1) - 1);
  localparam logic signed [EXP_W+1:0] EXP_MAX_S = (EXP_W+2)'(2**EXP_W - 1);
  localparam logic signed [EXP_W+1:0] EXP_ONE_S = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] ZERO_S    = (EXP_W+2)'(0);
`ifdef FP_DIV_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sign_q, sign_d;
  logic signed [EXP_W+1:0]  exp_q, exp_d;
  logic [MAN_W:0]           div_q, div_d;
  logic [R_W-1:0]           rem_q, rem_d;
  logic [Q_W-1:0]           quo_q, quo_d;
  logic [W-1:0]             res_q, res_d;
  logic [3:0]               flags_q, flags_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;

  logic                     spec_hit_s;
  logic [W-1:0]             spec_res_s;
  logic [3:0]               spec_flags_s;
  logic                     ge_s;
  logic [R_W-1:0]           rem_step_s;
  logic [MAN_W-1:0]         frac_raw_s;
  logic                     guard_s, rest_s, round_up_s;
  logic [MAN_W:0]           man_rnd_s;
  logic signed [EXP_W+1:0]  exp_n_s, exp_r_s;
  logic [W-1:0]             norm_res_s;
  logic [3:0]               norm_flags_s;

  fp_div_special #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_special (
    .a_i      (data_input_1),
    .b_i      (data_input_2),
    .hit_o    (spec_hit_s),
    .result_o (spec_res_s),
    .flags_o  (spec_flags_s)
  );

  // One restoring step: partial remainder never exceeds twice the divisor.
  assign ge_s       = (rem_q >= {1'b0, div_q});
  assign rem_step_s = ge_s ? (rem_q - {1'b0, div_q}) : rem_q;

  // Normalise the quotient, round, and range-check the exponent.
  always_comb begin
    norm_flags_s = 4'b0000;
    if (quo_q[Q_W-1]) begin
      frac_raw_s = quo_q[Q_W-2:2];
      guard_s    = quo_q[1];
      rest_s     = quo_q[0] | (rem_q != {R_W{1'b0}});
      exp_n_s    = exp_q;
    end else begin
      frac_raw_s = quo_q[Q_W-3:1];
      guard_s    = quo_q[0];
      rest_s     = (rem_q != {R_W{1'b0}});
      exp_n_s    = exp_q - EXP_ONE_S;
    end
    round_up_s = RNE_EN & guard_s & (rest_s | frac_raw_s[0]);
    man_rnd_s  = {1'b0, frac_raw_s} + {{MAN_W{1'b0}}, round_up_s};
    exp_r_s    = exp_n_s + $signed({{(EXP_W+1){1'b0}}, man_rnd_s[MAN_W]});
    if (exp_r_s >= EXP_MAX_S) begin
      norm_res_s            = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags_s[FLG_OVF] = 1'b1;
    end else if (exp_r_s <= ZERO_S) begin
      norm_res_s            = {sign_q, {(EXP_W+MAN_W){1'b0}}};
      norm_flags_s[FLG_UDF] = 1'b1;
    end else begin
      norm_res_s            = {sign_q, exp_r_s[EXP_W-1:0], man_rnd_s[MAN_W-1:0]};
    end
  end

  // FSM next-state and datapath load/step decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    div_d       = div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    res_d       = res_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = data_input_1[W-1] ^ data_input_2[W-1];
          exp_d  = $signed({2'b00, data_input_1[W-2:MAN_W]})
                 - $signed({2'b00, data_input_2[W-2:MAN_W]}) + BIAS_S;
          div_d  = {1'b1, data_input_2[MAN_W-1:0]};
          rem_d  = {1'b0, 1'b1, data_input_1[MAN_W-1:0]};
          quo_d  = {Q_W{1'b0}};
          cnt_d  = {CNT_W{1'b0}};
          if (spec_hit_s) begin
            res_d       = spec_res_s;
            flags_d     = spec_flags_s;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d     = ST_DIVIDE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        quo_d = {quo_q[Q_W-2:0], ge_s};
        rem_d = {rem_step_s[R_W-2:0], 1'b0};
        if (cnt_q == LAST_CNT) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_NORM;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_NORM: begin
        res_d       = norm_res_s;
        flags_d     = norm_flags_s;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      sign_q      <= 1'b0;
      exp_q       <= ZERO_S;
      div_q       <= {(MAN_W+1){1'b0}};
      rem_q       <= {R_W{1'b0}};
      quo_q       <= {Q_W{1'b0}};
      res_q       <= {W{1'b0}};
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign data_output = res_q;
  assign flags       = flags_q;

endmodule
